// File: rtl/conv2d_pkg.sv
// Shared types and arithmetic helpers for the streaming convolution engine
// and the CNN feature stages that consume its output.
package conv2d_pkg;

  localparam int MAX_KERNEL_DIM = 7;

  typedef logic [$clog2(MAX_KERNEL_DIM*MAX_KERNEL_DIM)-1:0] coef_idx_t;

  // Width of a KxK sum of (unsigned pixel x signed coefficient) products.
  function automatic int acc_width(input int word_size, input int coef_width,
                                   input int kernel_dim);
    return word_size + 1 + coef_width + $clog2(kernel_dim * kernel_dim);
  endfunction

  // Generalised Laplacian: the centre tap balances all the -1 taps around it.
  function automatic int laplacian_coef(input int kernel_dim, input coef_idx_t idx);
    return (int'(idx) == (kernel_dim * kernel_dim) / 2) ? kernel_dim * kernel_dim - 1 : -1;
  endfunction

  function automatic logic [31:0] shift_abs_clamp(input logic signed [63:0] acc,
                                                  input int unsigned shift,
                                                  input logic abs_en,
                                                  input int unsigned word_size);
    logic signed [63:0] s;
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< word_size) - 64'sd1;
    s = acc >>> shift;
    if (s < 64'sd0) s = abs_en ? -s : 64'sd0;
    if (s > max_v) s = max_v;
    return s[31:0];
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// K-1 row memories indexed by column; presents the K-tall column ending at
// the incoming pixel (index 0 = oldest row).
module conv_line_buffer
  import conv2d_pkg::*;
#(
  parameter int WORD_SIZE    = 8,
  parameter int KERNEL_DIM   = 3,
  parameter int MAX_ROW_SIZE = 1024,
  localparam int COL_IDX_W   = $clog2(MAX_ROW_SIZE)
) (
  input  logic                                  clk,
  input  logic                                  en,
  input  logic [COL_IDX_W-1:0]                  col,
  input  logic [WORD_SIZE-1:0]                  pix,
  output logic [KERNEL_DIM-1:0][WORD_SIZE-1:0]  column
);

  // mem[0] holds the previous row, mem[K-2] the oldest one.
  logic [WORD_SIZE-1:0] mem [KERNEL_DIM-1][MAX_ROW_SIZE];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0][col] <= pix;
      for (int i = 1; i < KERNEL_DIM - 1; i++) mem[i][col] <= mem[i-1][col];
    end
  end

  always_comb begin
    column[KERNEL_DIM-1] = pix;
    for (int r = 0; r < KERNEL_DIM - 1; r++) column[r] = mem[KERNEL_DIM-2-r][col];
  end

endmodule

// File: rtl/conv2d_stream.sv
// Streaming KxK convolution with runtime kernel, row width, shift and abs mode;
// window stage followed by multiply, sum and shift/clamp register stages.
module conv2d_stream
  import conv2d_pkg::*;
#(
  parameter int WORD_SIZE     = 8,
  parameter int COEF_WIDTH    = 8,
  parameter int KERNEL_DIM    = 3,
  parameter int MAX_ROW_SIZE  = 1024,
  parameter int SHIFT_W       = 4,
  localparam int ROW_SIZE_W   = $clog2(MAX_ROW_SIZE + 1),
  localparam int COEF_ADDR_W  = $clog2(KERNEL_DIM * KERNEL_DIM)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [ROW_SIZE_W-1:0]        cfg_row_size,
  input  logic [SHIFT_W-1:0]           cfg_shift,
  input  logic                         cfg_abs,
  input  logic                         coef_we,
  input  logic [COEF_ADDR_W-1:0]       coef_addr,
  input  logic signed [COEF_WIDTH-1:0] coef_data,
  input  logic                         in_valid,
  input  logic [WORD_SIZE-1:0]         in_data,
  input  logic                         in_sof,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WORD_SIZE-1:0]         out_data,
  output logic                         out_sof,
  output logic                         out_eol,
  input  logic                         out_ready
);

  localparam int KK        = KERNEL_DIM * KERNEL_DIM;
  localparam int ACC_W     = acc_width(WORD_SIZE, COEF_WIDTH, KERNEL_DIM);
  localparam int PROD_W    = WORD_SIZE + 1 + COEF_WIDTH;
  localparam int COL_IDX_W = $clog2(MAX_ROW_SIZE);
  localparam int ROW_W     = $clog2(KERNEL_DIM);
  localparam logic [ROW_W-1:0]      K_LAST_ROW = ROW_W'(KERNEL_DIM - 1);
  localparam logic [ROW_SIZE_W-1:0] K_LAST_COL = ROW_SIZE_W'(KERNEL_DIM - 1);

  // Handshake: a pixel moves on in_valid && in_ready, a result on
  // out_valid && out_ready. A held output freezes every stage, so in_ready
  // is simply the absence of that stall.
  logic stall, advance, accept;
  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign advance  = !stall;
  assign accept   = in_valid && in_ready;

  logic [ROW_SIZE_W-1:0] col_q, row_size_q;
  logic [ROW_W-1:0]      row_q;
  logic [SHIFT_W-1:0]    shift_q;
  logic                  abs_q, sof_pend;
  logic signed [COEF_WIDTH-1:0] shadow_q [KK];
  logic signed [COEF_WIDTH-1:0] active_q [KK];

  logic [ROW_SIZE_W-1:0] rs_load, eff_rs, cur_col, nxt_col;
  logic [ROW_W-1:0]      cur_row, nxt_row;
  logic                  at_eol, win_done;

  // SOF overrides the counters and row size for the pixel that carries it.
  always_comb begin
    rs_load = cfg_row_size;
    if (cfg_row_size < ROW_SIZE_W'(KERNEL_DIM)) rs_load = ROW_SIZE_W'(KERNEL_DIM);
    else if (cfg_row_size > ROW_SIZE_W'(MAX_ROW_SIZE)) rs_load = ROW_SIZE_W'(MAX_ROW_SIZE);
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    eff_rs   = in_sof ? rs_load : row_size_q;
    at_eol   = (cur_col == eff_rs - ROW_SIZE_W'(1));
    nxt_col  = at_eol ? '0 : cur_col + ROW_SIZE_W'(1);
    nxt_row  = cur_row;
    if (at_eol && cur_row != K_LAST_ROW) nxt_row = cur_row + ROW_W'(1);
    win_done = accept && (cur_row >= K_LAST_ROW) && (cur_col >= K_LAST_COL);
  end

  logic [KERNEL_DIM-1:0][WORD_SIZE-1:0] column;

  conv_line_buffer #(
    .WORD_SIZE    (WORD_SIZE),
    .KERNEL_DIM   (KERNEL_DIM),
    .MAX_ROW_SIZE (MAX_ROW_SIZE)
  ) u_line_buffer (
    .clk    (clk),
    .en     (accept),
    .col    (cur_col[COL_IDX_W-1:0]),
    .pix    (in_data),
    .column (column)
  );

  logic [WORD_SIZE-1:0]     win_q [KERNEL_DIM][KERNEL_DIM];
  logic signed [PROD_W-1:0] prod_d [KK];
  logic signed [PROD_W-1:0] prod_q [KK];
  logic signed [ACC_W-1:0]  sum_d, sum_q;
  logic [SHIFT_W-1:0]       s1_shift, s2_shift;
  logic                     s1_abs, s2_abs;
  logic win_valid, win_sof, win_eol;
  logic s1_valid, s1_sof, s1_eol;
  logic s2_valid, s2_sof, s2_eol;

  always_comb begin
    for (int r = 0; r < KERNEL_DIM; r++)
      for (int c = 0; c < KERNEL_DIM; c++)
        prod_d[r*KERNEL_DIM+c] = PROD_W'($signed({1'b0, win_q[r][c]}))
                               * PROD_W'(active_q[r*KERNEL_DIM+c]);
    sum_d = '0;
    for (int i = 0; i < KK; i++) sum_d = sum_d + ACC_W'(prod_q[i]);
  end

  // Shift/abs travel with the data so a new frame's cfg never touches old results.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < KERNEL_DIM; r++) begin
        for (int c = 0; c < KERNEL_DIM - 1; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][KERNEL_DIM-1] <= column[r];
      end
    end
    if (advance) begin
      for (int i = 0; i < KK; i++) prod_q[i] <= prod_d[i];
      s1_shift <= shift_q;
      s1_abs   <= abs_q;
      sum_q    <= sum_d;
      s2_shift <= s1_shift;
      s2_abs   <= s1_abs;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      row_size_q <= ROW_SIZE_W'(MAX_ROW_SIZE);
      shift_q    <= '0;
      abs_q      <= 1'b0;
      sof_pend   <= 1'b0;
      win_valid  <= 1'b0;
      win_sof    <= 1'b0;
      win_eol    <= 1'b0;
      s1_valid   <= 1'b0;
      s1_sof     <= 1'b0;
      s1_eol     <= 1'b0;
      s2_valid   <= 1'b0;
      s2_sof     <= 1'b0;
      s2_eol     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      for (int i = 0; i < KK; i++) begin
        shadow_q[i] <= COEF_WIDTH'(laplacian_coef(KERNEL_DIM, coef_idx_t'(i)));
        active_q[i] <= COEF_WIDTH'(laplacian_coef(KERNEL_DIM, coef_idx_t'(i)));
      end
    end else begin
      if (coef_we && coef_addr < COEF_ADDR_W'(KK)) shadow_q[coef_addr] <= coef_data;
      if (accept) begin
        col_q <= nxt_col;
        row_q <= nxt_row;
        if (in_sof) begin
          row_size_q <= rs_load;
          shift_q    <= cfg_shift;
          abs_q      <= cfg_abs;
          sof_pend   <= 1'b1;
          for (int i = 0; i < KK; i++) active_q[i] <= shadow_q[i];
        end else if (win_done) begin
          sof_pend <= 1'b0;
        end
      end
      if (advance) begin
        win_valid <= win_done;
        win_sof   <= win_done && sof_pend;
        win_eol   <= win_done && at_eol;
        s1_valid  <= win_valid;
        s1_sof    <= win_sof;
        s1_eol    <= win_eol;
        s2_valid  <= s1_valid;
        s2_sof    <= s1_sof;
        s2_eol    <= s1_eol;
        out_valid <= s2_valid;
        out_sof   <= s2_sof;
        out_eol   <= s2_eol;
        out_data  <= WORD_SIZE'(shift_abs_clamp(64'(sum_q), 32'(s2_shift), s2_abs, WORD_SIZE));
      end
    end
  end

endmodule

// File: tb/tb_conv2d_stream.sv
// Directed frame scenarios for conv2d_stream checked against a direct 2-D
// convolution model and hand-computed output counts and sums.
module tb_conv2d_stream;

  localparam int W    = 8;
  localparam int K    = 3;
  localparam int MAXR = 1024;
  localparam int RSW  = $clog2(MAXR + 1);
  localparam int CAW  = $clog2(K * K);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [RSW-1:0]       cfg_row_size;
  logic [3:0]           cfg_shift;
  logic                 cfg_abs;
  logic                 coef_we;
  logic [CAW-1:0]       coef_addr;
  logic signed [7:0]    coef_data;
  logic                 in_valid;
  logic [W-1:0]         in_data;
  logic                 in_sof;
  logic                 in_ready;
  logic                 out_valid;
  logic [W-1:0]         out_data;
  logic                 out_sof;
  logic                 out_eol;
  logic                 out_ready;

  conv2d_stream dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_row_size (cfg_row_size),
    .cfg_shift    (cfg_shift),
    .cfg_abs      (cfg_abs),
    .coef_we      (coef_we),
    .coef_addr    (coef_addr),
    .coef_data    (coef_data),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_sof       (in_sof),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_sof      (out_sof),
    .out_eol      (out_eol),
    .out_ready    (out_ready)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [W+1:0] exp_q[$];
  int  img [8][16];
  int  m_shadow [9];
  int  m_active [9];
  int  outs_seen, out_sum, first_cyc, acc22;
  bit  first_seen;
  bit  rand_ready = 1'b0;

  typedef struct {
    int rows; int cols; int cfg_rs; int shift; bit abs_en;
    int pat; int val; bit rnd; int pause_at; int sof_waddr; int sof_wdata;
    int abort_at; bit chk_lat; int exp_count; int exp_sum;
  } case_t;

  case_t cases [10];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 9; i++) begin
      m_shadow[i] = (i == 4) ? 8 : -1;
      m_active[i] = m_shadow[i];
    end
  endtask

  function automatic int ref_val(input int r, input int c, input int shift, input bit abs_en);
    int s;
    s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        s += img[r-2+i][c-2+j] * m_active[i*3+j];
    s = s >>> shift;
    if (s < 0) s = abs_en ? -s : 0;
    if (s > 255) s = 255;
    return s;
  endfunction

  // ---------------- downstream ready ----------------
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (rst_n) begin
      check("in_ready", int'(in_ready), int'(!(out_valid && !out_ready)));
      if (out_valid && !first_seen) begin
        first_seen = 1'b1;
        first_cyc  = cyc;
      end
      if (out_valid && out_ready) begin
        outs_seen++;
        out_sum += int'(out_data);
        if (exp_q.size() == 0) begin
          check("unexpected_out", int'({out_sof, out_eol, out_data}), -1);
        end else begin
          e = exp_q.pop_front();
          check("out_sof_eol_data", int'({out_sof, out_eol, out_data}), int'(e));
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_pixel(input logic [W-1:0] d, input logic sof);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 1000) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic run_case(input case_t t);
    int idx;
    int n;
    bit aborted;
    for (int r = 0; r < t.rows; r++)
      for (int c = 0; c < t.cols; c++)
        case (t.pat)
          0:       img[r][c] = t.val;
          1:       img[r][c] = (r == 2 && c == 3) ? 200 : 0;
          default: img[r][c] = $urandom_range(0, 255);
        endcase
    m_active = m_shadow;
    if (t.sof_waddr >= 0) m_shadow[t.sof_waddr] = t.sof_wdata;
    for (int r = 2; r < t.rows; r++)
      for (int c = 2; c < t.cols; c++)
        exp_q.push_back({(r == 2 && c == 2), (c == t.cols - 1),
                         W'(ref_val(r, c, t.shift, t.abs_en))});
    outs_seen    = 0;
    out_sum      = 0;
    first_seen   = 1'b0;
    rand_ready   = t.rnd;
    cfg_row_size = RSW'(t.cfg_rs);
    cfg_shift    = 4'(t.shift);
    cfg_abs      = t.abs_en;
    aborted      = 1'b0;
    for (int r = 0; r < t.rows; r++) begin
      for (int c = 0; c < t.cols; c++) begin
        idx = r * t.cols + c;
        if (!aborted && idx == t.abort_at) begin
          in_valid = 1'b0;
          in_sof   = 1'b0;
          check("pre_reset_out_valid", int'(out_valid), 1);
          rst_n = 1'b0;
          #1;
          check("reset_out_valid", int'(out_valid), 0);
          check("reset_out_data", int'(out_data), 0);
          exp_q.delete();
          model_reset();
          @(posedge clk);
          #1;
          rst_n   = 1'b1;
          aborted = 1'b1;
        end
        if (!aborted) begin
          if (idx == 0 && t.sof_waddr >= 0) begin
            coef_we   = 1'b1;
            coef_addr = CAW'(t.sof_waddr);
            coef_data = 8'(t.sof_wdata);
          end
          send_pixel(W'(img[r][c]), idx == 0);
          coef_we = 1'b0;
          if (r == 2 && c == 2) acc22 = cyc;
          if (idx == t.pause_at) begin
            in_valid = 1'b0;
            for (int k = 0; k < 9; k++) begin
              coef_we   = 1'b1;
              coef_addr = CAW'(k);
              coef_data = 8'sd1;
              m_shadow[k] = 1;
              @(posedge clk);
              #1;
            end
            coef_we = 1'b0;
          end
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
    n = 0;
    while (exp_q.size() > 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    rand_ready = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    if (t.exp_count >= 0) check("out_count", outs_seen, t.exp_count);
    if (t.exp_sum >= 0)   check("out_sum", out_sum, t.exp_sum);
    if (t.chk_lat)        check("first_latency", first_cyc - acc22, 3);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //           rows cols rs sh abs pat val rnd pause waddr wdata abort lat count sum
    cases[0] = '{4, 8,  8,  0, 0, 0, 100, 0, -1, -1, 0, -1, 1, 12, 0};
    cases[1] = '{5, 8,  8,  0, 0, 1, 0,   0, -1, -1, 0, -1, 0, 18, 255};
    cases[2] = '{5, 8,  8,  0, 1, 1, 0,   0, -1, -1, 0, -1, 0, 18, 1855};
    cases[3] = '{6, 16, 16, 0, 0, 2, 0,   1, -1, -1, 0, -1, 0, 56, -1};
    cases[4] = '{5, 8,  8,  0, 0, 2, 0,   0, 20, -1, 0, -1, 0, 18, -1};
    cases[5] = '{4, 8,  8,  3, 0, 0, 80,  0, -1, 4,  5, -1, 0, 12, 1080};
    cases[6] = '{4, 5,  5,  3, 0, 0, 80,  0, -1, -1, 0, -1, 0, 6,  780};
    cases[7] = '{4, 3,  1,  3, 0, 0, 80,  0, -1, -1, 0, -1, 0, 2,  260};
    cases[8] = '{5, 8,  8,  0, 0, 2, 0,   0, -1, -1, 0, 30, 0, -1, -1};
    cases[9] = '{5, 8,  8,  0, 0, 1, 0,   0, -1, -1, 0, -1, 0, 18, 255};

    cfg_row_size = RSW'(8);
    cfg_shift    = '0;
    cfg_abs      = 1'b0;
    coef_we      = 1'b0;
    coef_addr    = '0;
    coef_data    = '0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_sof       = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid0", int'(out_valid), 0);
    check("reset_out_data0", int'(out_data), 0);
    check("reset_out_sof0", int'(out_sof), 0);
    check("reset_out_eol0", int'(out_eol), 0);
    check("reset_in_ready0", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) run_case(cases[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/conv2d_stream.md
Name: conv2d_stream

Overview:
- Streaming 2-D convolution engine that generalises the fixed 3x3 Laplacian edge filter.
- Runtime-loadable signed KxK kernel, runtime row width, output scaling shift and optional absolute-value mode.
- Valid/ready handshakes on both sides; frame-start and end-of-row markers on the output.
- Sits between the pixel source (camera/DMA unpacker) and downstream CNN feature stages.

Parameters:
- WORD_SIZE, 8, pixel width (unsigned).
- COEF_WIDTH, 8, kernel coefficient width (signed, two's complement).
- KERNEL_DIM, 3, kernel side; must be odd, 3..7.
- MAX_ROW_SIZE, 1024, maximum row length; sizes the line buffers.
- SHIFT_W, 4, width of the output right-shift control.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_row_size  in  $clog2(MAX_ROW_SIZE+1)  row length; sampled on accepted SOF pixel.
- cfg_shift  in  SHIFT_W  arithmetic right shift applied to the sum; sampled on SOF.
- cfg_abs  in  1  1 = take magnitude before clamp, 0 = negatives clamp to 0; sampled on SOF.
- coef_we  in  1  write strobe into the shadow coefficient bank.
- coef_addr  in  $clog2(KERNEL_DIM*KERNEL_DIM)  row-major coefficient index (row*K+col).
- coef_data  in  COEF_WIDTH  signed coefficient.
- in_valid  in  1  input pixel valid.
- in_data  in  WORD_SIZE  input pixel, raster order.
- in_sof  in  1  marks first pixel of a frame.
- in_ready  out  1  engine can accept a pixel.
- out_valid  out  1  output pixel valid.
- out_data  out  WORD_SIZE  clamped result.
- out_sof  out  1  first output of the frame.
- out_eol  out  1  last output of a row.
- out_ready  in  1  downstream accepts output.

Behaviour:
- Reset (async assert, sync release):
  - out_valid, out_data, out_sof, out_eol = 0.
  - Column/row counters = 0; pipeline valid bits = 0.
  - Active and shadow coefficients = generalised Laplacian: centre = K*K-1, all others = -1.
  - Active cfg: row_size = MAX_ROW_SIZE, shift = 0, abs = 0.
  - Line buffer contents are don't-care.
- Handshake:
  - Input accepted when in_valid && in_ready.
  - Output transfers when out_valid && out_ready.
  - stall = out_valid && !out_ready; in_ready = !stall (combinational).
  - The whole pipeline freezes on stall; out_* stay stable until accepted.
- Line buffering:
  - K-1 row buffers of MAX_ROW_SIZE words plus a KxK window register.
  - All advance only on an accepted pixel.
- Counters:
  - col wraps at active row_size-1, then row increments, saturating at K-1.
  - Accepted pixel with in_sof forces col = 0, row = 0 before use.
  - The same SOF pixel loads cfg_* into active cfg and copies shadow coefs to active coefs.
  - cfg_row_size outside [KERNEL_DIM, MAX_ROW_SIZE] is clamped to that range on load.
- Window validity ("valid" convolution, no padding):
  - An accepted pixel at (row >= K-1, col >= K-1) completes a window.
  - Yields (row_size-K+1) outputs per row; first K-1 rows produce none.
  - out_eol is set when col == row_size-1.
  - out_sof is set on the first window after SOF.
- Pipeline, 3 register stages:
  - S1: K*K products, pixel zero-extended to signed WORD_SIZE+1, times coef.
  - S2: sum, width ACC_W = WORD_SIZE+1+COEF_WIDTH+$clog2(K*K), no overflow possible.
  - S3: arithmetic >>> cfg_shift, optional abs, clamp to [0, 2^WORD_SIZE-1], register to out_data.
- Latency: out_valid asserts 3 cycles after the completing pixel is accepted, absent stalls. Sustained throughput is 1 pixel/clk.
- Coefficient writes:
  - Go to the shadow bank only; may occur any cycle, including during stall.
  - Never affect the frame in flight.
  - A write coincident with an accepted SOF pixel is NOT included in that commit.
- Mid-frame SOF: counters restart; outputs already in S1..S3 still drain with their original flags.
- Reset mid-operation: pending outputs are lost, coefs revert to the Laplacian, and the next frame refills from scratch.

Decomposition:
- Package conv2d_pkg holds:
  - ACC_W computation function.
  - Coefficient index type.
  - Default-Laplacian coefficient function.
  - Shift/abs/clamp function shared with other CNN stages.
- One sub-module, conv_line_buffer:
  - K-1 row FIFOs addressed by column, with an enable input.
  - Outputs the K-tall column feeding the window shifter.

Test Plan:
- Uniform frame, W=8, 4 rows of value 100, default kernel, out_ready=1 -> 12 outputs, all 0; out_eol on every 6th; out_sof on first only; first out_valid 3 cycles after pixel (2,2).
- Single pixel 200 at (2,3) in a zero frame, W=8, abs=0 -> 1600 clamps to 255 at the centre output, neighbours 0; with abs=1 the neighbours are 200.
- Random out_ready (50%) on a 16x6 random frame -> output sequence bit-identical to the out_ready=1 run; no drops or duplicates; in_ready low exactly while stalled.
- Load box kernel (all 1) and shift=3 mid-frame, then SOF with uniform 80 -> old frame still Laplacian; new frame outputs 90 (720>>3).
- cfg_row_size=5 at SOF -> 3 outputs per row, out_eol on each 3rd; cfg_row_size=1 -> clamped to 3, one output per row.
- rst_n low for 1 cycle during row 3 -> out_valid drops immediately; next frame with the Laplacian produces correct results from scratch.
